mac_tile_dual: RTL and testbench

Second-generation processing element for the systolic MAC array. It supports both dataflows selected per tile:
- **Weight-stationary (WS):** the successor of the current tile, with weight re-arm.
- **Output-stationary (OS):** the tile keeps a local accumulator, streams weights south and drains results down the column on a flush.

Data widths are parametrised. Reset is asynchronous. Instructions propagate east with one cycle of delay.

---
 rtl/mac_tile_dual.sv | 122 ++++++++++++
 tb/tb_mac_tile_dual.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/mac_tile_dual.sv
// rtl/mac_tile_dual.sv - dual-dataflow (weight-/output-stationary) systolic MAC tile
module mac_tile_dual #(
  parameter int bw      = 4,
  parameter int psum_bw = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               os_mode,
  input  logic [bw-1:0]      in_w,
  output logic [bw-1:0]      out_e,
  input  logic [2:0]         inst_w,
  output logic [2:0]         inst_e,
  input  logic [psum_bw-1:0] in_n,
  output logic [psum_bw-1:0] out_s,
  output logic               valid_s
);

  logic [bw-1:0]      a_q;
  logic [bw-1:0]      b_q;
  logic [psum_bw-1:0] c_q;
  logic [psum_bw-1:0] acc_q;
  logic [psum_bw-1:0] s_q;
  logic [2:0]         inst_q;
  logic               load_ready_q;
  logic               mode_q;

  logic                      ws_active;
  logic                      ws_load;
  logic                      os_exec;
  logic                      os_flush;
  logic signed [bw-1:0]      in_n_lo;
  logic signed [2*bw-1:0]    ws_prod;
  logic signed [2*bw-1:0]    os_prod;
  logic signed [psum_bw-1:0] ws_prod_ext;
  logic signed [psum_bw-1:0] os_prod_ext;
  logic signed [psum_bw-1:0] in_n_lo_ext;
  logic [psum_bw-1:0]        ws_sum;

  assign ws_active = !mode_q && (inst_w[0] || inst_w[1]);
  assign ws_load   = !mode_q && inst_w[0] && load_ready_q;
  assign os_flush  = mode_q && inst_w[2];
  assign os_exec   = mode_q && inst_w[1] && !inst_w[2];

  assign in_n_lo     = in_n[bw-1:0];
  assign ws_prod     = $signed(a_q) * $signed(b_q);
  assign os_prod     = $signed(in_w) * in_n_lo;
  assign ws_prod_ext = psum_bw'(ws_prod);
  assign os_prod_ext = psum_bw'(os_prod);
  assign in_n_lo_ext = psum_bw'(in_n_lo);
  assign ws_sum      = ws_prod_ext + c_q;

  // mode only switches on an idle edge so in-flight instructions keep their dataflow
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mode_q <= 1'b0;
    end else if (inst_w == 3'b000) begin
      mode_q <= os_mode;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      inst_q <= 3'b000;
    end else begin
      inst_q[2:1] <= inst_w[2:1];
      // WS: the first load after arming is consumed here, later loads go east
      inst_q[0]   <= mode_q ? inst_w[0] : (inst_w[0] && !load_ready_q);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      load_ready_q <= 1'b1;
    end else if (!mode_q) begin
      if (inst_w[2]) begin
        load_ready_q <= 1'b1;
      end else if (ws_load) begin
        load_ready_q <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      a_q <= '0;
      b_q <= '0;
      c_q <= '0;
    end else begin
      if (ws_active) begin
        a_q <= in_w;
        c_q <= in_n;
      end
      if (ws_load) begin
        b_q <= in_w;
      end
      if (os_exec) begin
        a_q <= in_w;
        b_q <= in_n[bw-1:0];
      end
    end
  end

  // OS flush shifts the accumulator south and pulls the northern one in
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc_q <= '0;
      s_q   <= '0;
    end else if (os_flush) begin
      s_q   <= acc_q;
      acc_q <= in_n;
    end else if (os_exec) begin
      acc_q <= acc_q + os_prod_ext;
      s_q   <= in_n_lo_ext;
    end
  end

  assign out_e   = a_q;
  assign inst_e  = inst_q;
  assign out_s   = mode_q ? s_q : ws_sum;
  assign valid_s = mode_q ? inst_q[2] : inst_q[1];

endmodule

// File: tb/tb_mac_tile_dual.sv
// tb/tb_mac_tile_dual.sv - directed-vector bench for mac_tile_dual
module tb_mac_tile_dual;

  logic        clk;
  logic        reset;
  logic        os_mode;
  logic [3:0]  in_w;
  logic [3:0]  out_e;
  logic [2:0]  inst_w;
  logic [2:0]  inst_e;
  logic [15:0] in_n;
  logic [15:0] out_s;
  logic        valid_s;

  int vecs;
  int errs;

  mac_tile_dual #(.bw(4), .psum_bw(16)) dut (
    .clk     (clk),
    .reset   (reset),
    .os_mode (os_mode),
    .in_w    (in_w),
    .out_e   (out_e),
    .inst_w  (inst_w),
    .inst_e  (inst_e),
    .in_n    (in_n),
    .out_s   (out_s),
    .valid_s (valid_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [2:0] i, input logic [3:0] w, input logic [15:0] n);
    inst_w = i;
    in_w   = w;
    in_n   = n;
  endtask

  task automatic do_reset();
    drive(3'b000, 4'd0, 16'd0);
    os_mode = 1'b0;
    reset = 1'b0;
    step();
    reset = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    vecs++; if (out_e !== 4'd0) begin $display("FAIL reset_out_e got %h want %h", out_e, 4'd0); errs++; end
    vecs++; if (inst_e !== 3'd0) begin $display("FAIL reset_inst_e got %b want %b", inst_e, 3'd0); errs++; end
    vecs++; if (out_s !== 16'd0) begin $display("FAIL reset_out_s got %h want %h", out_s, 16'd0); errs++; end
    vecs++; if (valid_s !== 1'b0) begin $display("FAIL reset_valid_s got %b want %b", valid_s, 1'b0); errs++; end
  endtask

  task automatic test_ws_load();
    do_reset();
    drive(3'b001, 4'd3, 16'd0); step();
    vecs++; if (inst_e !== 3'b000) begin $display("FAIL ws_load1_inst_e got %b want %b", inst_e, 3'b000); errs++; end
    vecs++; if (out_e !== 4'd3) begin $display("FAIL ws_load1_out_e got %h want %h", out_e, 4'd3); errs++; end
    drive(3'b001, 4'd5, 16'd0); step();
    vecs++; if (inst_e !== 3'b001) begin $display("FAIL ws_load2_inst_e got %b want %b", inst_e, 3'b001); errs++; end
    vecs++; if (out_e !== 4'd5) begin $display("FAIL ws_load2_out_e got %h want %h", out_e, 4'd5); errs++; end
  endtask

  task automatic test_ws_execute();
    // weight 3 still resident from test_ws_load
    drive(3'b010, 4'hE, 16'd10); step();
    vecs++; if (out_s !== 16'd4) begin $display("FAIL ws_exec_out_s got %h want %h", out_s, 16'd4); errs++; end
    vecs++; if (valid_s !== 1'b1) begin $display("FAIL ws_exec_valid got %b want %b", valid_s, 1'b1); errs++; end
    vecs++; if (inst_e !== 3'b010) begin $display("FAIL ws_exec_inst_e got %b want %b", inst_e, 3'b010); errs++; end
    drive(3'b000, 4'd0, 16'd0); step();
    vecs++; if (valid_s !== 1'b0) begin $display("FAIL ws_idle_valid got %b want %b", valid_s, 1'b0); errs++; end
    vecs++; if (out_s !== 16'd4) begin $display("FAIL ws_idle_hold got %h want %h", out_s, 16'd4); errs++; end
    do_reset();
    drive(3'b001, 4'd7, 16'd0); step();
    drive(3'b010, 4'd7, 16'h7FFF); step();
    vecs++; if (out_s !== 16'h8030) begin $display("FAIL ws_wrap_out_s got %h want %h", out_s, 16'h8030); errs++; end
  endtask

  task automatic test_ws_rearm();
    do_reset();
    drive(3'b001, 4'd3, 16'd0); step();
    drive(3'b100, 4'd0, 16'd0); step();
    drive(3'b001, 4'd6, 16'd0); step();
    vecs++; if (inst_e !== 3'b000) begin $display("FAIL rearm_load_inst_e got %b want %b", inst_e, 3'b000); errs++; end
    drive(3'b001, 4'd2, 16'd0); step();
    vecs++; if (inst_e !== 3'b001) begin $display("FAIL rearm_fwd_inst_e got %b want %b", inst_e, 3'b001); errs++; end
    drive(3'b010, 4'd1, 16'd0); step();
    vecs++; if (out_s !== 16'd6) begin $display("FAIL rearm_weight got %h want %h", out_s, 16'd6); errs++; end
    // re-arm together with load: load sees old (cleared) ready, then ready ends set
    drive(3'b101, 4'd9, 16'd0); step();
    vecs++; if (inst_e !== 3'b101) begin $display("FAIL rearm_load_combo_inst_e got %b want %b", inst_e, 3'b101); errs++; end
    drive(3'b001, 4'd2, 16'd0); step();
    vecs++; if (inst_e !== 3'b000) begin $display("FAIL rearm_combo_consume got %b want %b", inst_e, 3'b000); errs++; end
    drive(3'b010, 4'd1, 16'd0); step();
    vecs++; if (out_s !== 16'd2) begin $display("FAIL rearm_combo_weight got %h want %h", out_s, 16'd2); errs++; end
  endtask

  task automatic test_os_accumulate();
    do_reset();
    os_mode = 1'b1;
    drive(3'b000, 4'd0, 16'd0); step();
    drive(3'b010, 4'd2, 16'd3); step();
    vecs++; if (out_s !== 16'd3) begin $display("FAIL os_acc1_out_s got %h want %h", out_s, 16'd3); errs++; end
    vecs++; if (valid_s !== 1'b0) begin $display("FAIL os_acc1_valid got %b want %b", valid_s, 1'b0); errs++; end
    drive(3'b010, 4'hF, 16'd4); step();
    vecs++; if (out_s !== 16'd4) begin $display("FAIL os_acc2_out_s got %h want %h", out_s, 16'd4); errs++; end
    drive(3'b010, 4'd5, 16'h120E); step();
    vecs++; if (out_s !== 16'hFFFE) begin $display("FAIL os_acc3_out_s got %h want %h", out_s, 16'hFFFE); errs++; end
    vecs++; if (out_e !== 4'd5) begin $display("FAIL os_acc3_out_e got %h want %h", out_e, 4'd5); errs++; end
  endtask

  task automatic test_os_flush();
    drive(3'b100, 4'd0, 16'h0011); step();
    vecs++; if (out_s !== 16'hFFF8) begin $display("FAIL os_flush1_out_s got %h want %h", out_s, 16'hFFF8); errs++; end
    vecs++; if (valid_s !== 1'b1) begin $display("FAIL os_flush1_valid got %b want %b", valid_s, 1'b1); errs++; end
    drive(3'b110, 4'd0, 16'h0000); step();
    vecs++; if (out_s !== 16'h0011) begin $display("FAIL os_flush2_out_s got %h want %h", out_s, 16'h0011); errs++; end
    vecs++; if (valid_s !== 1'b1) begin $display("FAIL os_flush2_valid got %b want %b", valid_s, 1'b1); errs++; end
    drive(3'b000, 4'd0, 16'h0000); step();
    vecs++; if (valid_s !== 1'b0) begin $display("FAIL os_idle_valid got %b want %b", valid_s, 1'b0); errs++; end
    vecs++; if (out_s !== 16'h0011) begin $display("FAIL os_idle_hold got %h want %h", out_s, 16'h0011); errs++; end
  endtask

  task automatic test_async_reset();
    do_reset();
    drive(3'b001, 4'd3, 16'd0); step();
    drive(3'b010, 4'hE, 16'd10); step();
    @(negedge clk);
    reset = 1'b0;
    #1;
    vecs++; if (out_s !== 16'd0) begin $display("FAIL async_out_s got %h want %h", out_s, 16'd0); errs++; end
    vecs++; if (valid_s !== 1'b0) begin $display("FAIL async_valid got %b want %b", valid_s, 1'b0); errs++; end
    vecs++; if (out_e !== 4'd0) begin $display("FAIL async_out_e got %h want %h", out_e, 4'd0); errs++; end
    vecs++; if (inst_e !== 3'd0) begin $display("FAIL async_inst_e got %b want %b", inst_e, 3'd0); errs++; end
    drive(3'b000, 4'd0, 16'd0);
    reset = 1'b1;
    step();
  endtask

  task automatic test_mode_change();
    do_reset();
    os_mode = 1'b1;
    drive(3'b000, 4'd0, 16'd0); step();
    drive(3'b010, 4'd2, 16'd3); step();
    vecs++; if (out_s !== 16'd3) begin $display("FAIL mode_os_exec got %h want %h", out_s, 16'd3); errs++; end
    os_mode = 1'b0;
    drive(3'b010, 4'd1, 16'h0105); step();
    vecs++; if (out_s !== 16'h0005) begin $display("FAIL mode_inflight_hold got %h want %h", out_s, 16'h0005); errs++; end
    drive(3'b000, 4'd0, 16'd0); step();
    drive(3'b010, 4'd2, 16'd1); step();
    vecs++; if (out_s !== 16'd11) begin $display("FAIL mode_ws_after_idle got %h want %h", out_s, 16'd11); errs++; end
    vecs++; if (valid_s !== 1'b1) begin $display("FAIL mode_ws_valid got %b want %b", valid_s, 1'b1); errs++; end
  endtask

  initial begin
    vecs = 0;
    errs = 0;
    reset = 1'b0;
    os_mode = 1'b0;
    drive(3'b000, 4'd0, 16'd0);
    test_reset();
    test_ws_load();
    test_ws_execute();
    test_ws_rearm();
    test_os_accumulate();
    test_os_flush();
    test_async_reset();
    test_mode_change();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
